// File: rtl/core_pkg.sv
// Shared core definitions: memory opcodes, LSU access sizes, LSU FSM states,
// and the access legality check used when a request is accepted.
package core_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    // Unsupported sizes are folded into the misaligned case so they fault.
    function automatic logic lsu_misaligned(input logic [2:0] func3, input logic [1:0] lo);
        logic bad;
        case (func3)
            LSU_B, LSU_BU: bad = 1'b0;
            LSU_H, LSU_HU: bad = lo[0];
            LSU_W:         bad = (lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the LSU: byte strobes and replicated store
// data for the bus request, and byte/half extraction with sign or zero
// extension for returned load data.
module core_lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] rdata_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Strobes follow the byte offset; data is replicated so every lane carries it
    always_comb begin
        wstrb = 4'b1111;
        wdata = st_data;
        case (func3)
            LSU_B, LSU_BU: begin
                wstrb = 4'b0001 << ea_lo;
                wdata = {4{st_data[7:0]}};
            end
            LSU_H, LSU_HU: begin
                wstrb = 4'b0011 << ea_lo;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the word and extend it
    always_comb begin
        rdata_sh = rdata >> {ea_lo, 3'b000};
        byte_sel = rdata_sh[7:0];
        half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            LSU_B:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  ld_data = {24'd0, byte_sel};
            LSU_H:   ld_data = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  ld_data = {16'd0, half_sel};
            LSU_W:   ld_data = rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/core_lsu_mc.sv
// Multi-cycle load/store unit: accepts one access from IDU, issues a
// valid/ready bus request, waits (with timeout) for a variable-latency
// response and returns extended load data or an error to WBU.
// Optional: define LSU_DEBUG_DISPLAY_EN to trace bus requests/responses.
module core_lsu_mc
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            lsu_rx_valid,
    output logic            lsu_rx_ready,
    input  logic [6:0]      lsu_rx_opcode,
    input  logic [2:0]      lsu_rx_func3,
    input  logic [XLEN-1:0] lsu_rx_rs1_data,
    input  logic [XLEN-1:0] lsu_rx_rs2_data,
    input  logic [XLEN-1:0] lsu_rx_imme,
    input  logic [4:0]      lsu_rx_rd_idx,
    output logic            lsu_bus_req_valid,
    input  logic            lsu_bus_req_ready,
    output logic            lsu_bus_req_wen,
    output logic [XLEN-1:0] lsu_bus_req_addr,
    output logic [3:0]      lsu_bus_req_wstrb,
    output logic [XLEN-1:0] lsu_bus_req_wdata,
    input  logic            lsu_bus_rsp_valid,
    input  logic            lsu_bus_rsp_err,
    input  logic [XLEN-1:0] lsu_bus_rsp_rdata,
    output logic            lsu_tx_valid,
    input  logic            lsu_tx_ready,
    output logic [XLEN-1:0] lsu_tx_data,
    output logic [4:0]      lsu_tx_rd_idx,
    output logic            lsu_tx_err,
    output logic            lsu_busy
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("core_lsu_mc: only XLEN=32 is supported");
    end

    // WAIT exits on the cycle the counter would step onto all-ones,
    // giving 2^TIMEOUT_W-1 WAIT cycles in total.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    lsu_state_e            state, state_nxt;
    logic [TIMEOUT_W-1:0]  cnt;
    logic                  is_load;
    logic [2:0]            func3;
    logic [4:0]            rd_idx;
    logic [XLEN-1:0]       ea, rs2;
    logic [XLEN-1:0]       tx_data;
    logic [4:0]            tx_rd_idx;
    logic                  tx_err;

    logic [XLEN-1:0]       rx_ea;
    logic                  rx_is_mem, rx_misaligned;
    logic [3:0]            al_wstrb;
    logic [31:0]           al_wdata, al_ld_data;

    assign rx_ea         = lsu_rx_rs1_data + lsu_rx_imme;
    assign rx_is_mem     = (lsu_rx_opcode == LOAD) || (lsu_rx_opcode == STORE);
    assign rx_misaligned = lsu_misaligned(lsu_rx_func3, rx_ea[1:0]);

    core_lsu_align u_align (
        .func3   (func3),
        .ea_lo   (ea[1:0]),
        .st_data (rs2),
        .rdata   (lsu_bus_rsp_rdata),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ld_data (al_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= LSU_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a response wins over a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (lsu_rx_valid && rx_is_mem)
                          state_nxt = rx_misaligned ? LSU_RESP : LSU_REQ;
            LSU_REQ:  if (lsu_bus_req_ready) state_nxt = LSU_WAIT;
            LSU_WAIT: if (lsu_bus_rsp_valid)
                          state_nxt = (lsu_bus_rsp_err || is_load) ? LSU_RESP : LSU_IDLE;
                      else if (cnt == CNT_LAST)
                          state_nxt = LSU_RESP;
            LSU_RESP: if (lsu_tx_ready) state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    // Request latch, wait counter and WBU result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            is_load   <= 1'b0;
            func3     <= 3'd0;
            rd_idx    <= 5'd0;
            ea        <= '0;
            rs2       <= '0;
            tx_data   <= '0;
            tx_rd_idx <= 5'd0;
            tx_err    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: if (lsu_rx_valid && rx_is_mem) begin
                    is_load <= (lsu_rx_opcode == LOAD);
                    func3   <= lsu_rx_func3;
                    rd_idx  <= lsu_rx_rd_idx;
                    ea      <= rx_ea;
                    rs2     <= lsu_rx_rs2_data;
                    if (rx_misaligned) begin
                        tx_data   <= '0;
                        tx_err    <= 1'b1;
                        tx_rd_idx <= (lsu_rx_opcode == LOAD) ? lsu_rx_rd_idx : 5'd0;
                    end
                end
                LSU_REQ: cnt <= '0;
                LSU_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (lsu_bus_rsp_valid) begin
                        tx_err    <= lsu_bus_rsp_err;
                        tx_data   <= lsu_bus_rsp_err ? '0 : al_ld_data;
                        tx_rd_idx <= is_load ? rd_idx : 5'd0;
                    end else if (cnt == CNT_LAST) begin
                        tx_err    <= 1'b1;
                        tx_data   <= '0;
                        tx_rd_idx <= is_load ? rd_idx : 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_rx_ready      = (state == LSU_IDLE);
    assign lsu_busy          = (state != LSU_IDLE);
    assign lsu_bus_req_valid = (state == LSU_REQ);
    assign lsu_bus_req_wen   = lsu_bus_req_valid && !is_load;
    assign lsu_bus_req_addr  = lsu_bus_req_valid ? {ea[XLEN-1:2], 2'b00} : '0;
    assign lsu_bus_req_wstrb = lsu_bus_req_valid ? al_wstrb : 4'd0;
    assign lsu_bus_req_wdata = lsu_bus_req_valid ? al_wdata : '0;
    assign lsu_tx_valid      = (state == LSU_RESP);
    assign lsu_tx_data       = tx_data;
    assign lsu_tx_rd_idx     = tx_rd_idx;
    assign lsu_tx_err        = tx_err;

`ifdef LSU_DEBUG_DISPLAY_EN
    // Trace every accepted request and every response seen in WAIT
    always @(posedge clk) begin
        if (rstn && lsu_bus_req_valid && lsu_bus_req_ready)
            $display("lsu req addr=%h wstrb=%b wdata=%h", lsu_bus_req_addr,
                     lsu_bus_req_wstrb, lsu_bus_req_wdata);
        if (rstn && state == LSU_WAIT && lsu_bus_rsp_valid)
            $display("lsu rsp rdata=%h err=%b", lsu_bus_rsp_rdata, lsu_bus_rsp_err);
    end
`endif

endmodule

// File: tb/tb_core_lsu_mc.sv
// Scoreboard bench for core_lsu_mc: stimulus pushes expected bus requests and
// WBU results into queues, a bus responder model answers requests, and a
// monitor compares everything the DUT presents.
module tb_core_lsu_mc;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          wait_cyc;
    } tx_exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_valid, rx_ready;
    logic [6:0]  rx_opcode;
    logic [2:0]  rx_func3;
    logic [31:0] rx_rs1, rx_rs2, rx_imme;
    logic [4:0]  rx_rd;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        tx_valid, tx_ready, tx_err, busy;
    logic [31:0] tx_data;
    logic [4:0]  tx_rd;

    req_exp_t req_q[$];
    tx_exp_t  tx_q[$];
    int  nvec = 0, nerr = 0;
    bit  done = 0, stim_to = 0;

    int          cfg_stall = 0, cfg_late = 0;
    bit          cfg_drop = 0, cfg_err = 0;
    logic [31:0] cfg_rdata = 32'd0;

    always #5 clk = ~clk;

    core_lsu_mc #(.XLEN(32), .TIMEOUT_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .lsu_rx_valid(rx_valid), .lsu_rx_ready(rx_ready),
        .lsu_rx_opcode(rx_opcode), .lsu_rx_func3(rx_func3),
        .lsu_rx_rs1_data(rx_rs1), .lsu_rx_rs2_data(rx_rs2),
        .lsu_rx_imme(rx_imme), .lsu_rx_rd_idx(rx_rd),
        .lsu_bus_req_valid(req_valid), .lsu_bus_req_ready(req_ready),
        .lsu_bus_req_wen(req_wen), .lsu_bus_req_addr(req_addr),
        .lsu_bus_req_wstrb(req_wstrb), .lsu_bus_req_wdata(req_wdata),
        .lsu_bus_rsp_valid(rsp_valid), .lsu_bus_rsp_err(rsp_err),
        .lsu_bus_rsp_rdata(rsp_rdata),
        .lsu_tx_valid(tx_valid), .lsu_tx_ready(tx_ready),
        .lsu_tx_data(tx_data), .lsu_tx_rd_idx(tx_rd), .lsu_tx_err(tx_err),
        .lsu_busy(busy)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Bus responder: optional stall on req_ready, then a response one cycle
    // after the handshake, a late one, or none at all
    initial begin
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'd0;
            if (rstn && req_valid) begin
                repeat (cfg_stall) begin @(posedge clk); #1; end
                req_ready = 1'b1;
                @(posedge clk); #1;
                req_ready = 1'b0;
                if (!cfg_drop) begin
                    rsp_valid = 1'b1; rsp_err = cfg_err; rsp_rdata = cfg_rdata;
                end else if (cfg_late > 0) begin
                    repeat (cfg_late) begin @(posedge clk); #1; end
                    rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] rd);
        int n = 0;
        while (!rx_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) stim_to = 1;
        rx_opcode = op; rx_func3 = f3; rx_rs1 = rs1; rx_imme = imm; rx_rs2 = rs2; rx_rd = rd;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (busy && n < 100);
        if (n >= 100) stim_to = 1;
    endtask

    task automatic exp_req(input logic wen, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req_exp_t r;
        r.wen = wen; r.addr = a; r.wstrb = s; r.wdata = d;
        req_q.push_back(r);
    endtask

    task automatic exp_tx(input logic [31:0] d, input logic [4:0] rd, input logic e, input int w);
        tx_exp_t t;
        t.data = d; t.rd = rd; t.err = e; t.wait_cyc = w;
        tx_q.push_back(t);
    endtask

    // Directed stimulus
    initial begin
        int n;
        rstn = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
        rx_opcode = 7'd0; rx_func3 = 3'd0; rx_rs1 = 0; rx_rs2 = 0; rx_imme = 0; rx_rd = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // lw with WBU backpressure
        cfg_rdata = 32'hDEAD_BEEF; tx_ready = 1'b0;
        exp_req(1'b0, 32'h1004, 4'b1111, 32'd0);
        exp_tx(32'hDEAD_BEEF, 5'd5, 1'b0, 1);
        send(7'b0000011, 3'b010, 32'h1000, 32'd4, 32'd0, 5'd5);
        n = 0;
        while (!tx_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) stim_to = 1;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle();

        // lb / lbu at byte 3, lh / lhu at half 1
        cfg_rdata = 32'h80FF_0000;
        exp_req(1'b0, 32'h1000, 4'b1000, 32'd0); exp_tx(32'hFFFF_FF80, 5'd7, 1'b0, 1);
        send(7'b0000011, 3'b000, 32'h1000, 32'd3, 32'd0, 5'd7); wait_idle();
        exp_req(1'b0, 32'h1000, 4'b1000, 32'd0); exp_tx(32'h0000_0080, 5'd8, 1'b0, 1);
        send(7'b0000011, 3'b100, 32'h1000, 32'd3, 32'd0, 5'd8); wait_idle();
        exp_req(1'b0, 32'h1000, 4'b1100, 32'd0); exp_tx(32'hFFFF_80FF, 5'd9, 1'b0, 1);
        send(7'b0000011, 3'b001, 32'h1004, 32'hFFFF_FFFE, 32'd0, 5'd9); wait_idle();
        exp_req(1'b0, 32'h1000, 4'b1100, 32'd0); exp_tx(32'h0000_80FF, 5'd10, 1'b0, 1);
        send(7'b0000011, 3'b101, 32'h1004, 32'hFFFF_FFFE, 32'd0, 5'd10); wait_idle();

        // Async reset while in WAIT
        cfg_drop = 1; cfg_late = 0;
        exp_req(1'b0, 32'h6000, 4'b1111, 32'd0);
        send(7'b0000011, 3'b010, 32'h6000, 32'd0, 32'd0, 5'd4);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        cfg_drop = 0;
        @(posedge clk); #1;

        // sh: OK response produces no tx
        cfg_err = 0;
        exp_req(1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD);
        send(7'b0100011, 3'b001, 32'h2000, 32'd2, 32'h1234_ABCD, 5'd3); wait_idle();

        // sb with bus error: tx err, rd forced to 0
        cfg_err = 1;
        exp_req(1'b1, 32'h2000, 4'b0010, 32'h5555_5555); exp_tx(32'd0, 5'd0, 1'b1, 1);
        send(7'b0100011, 3'b000, 32'h2000, 32'd1, 32'h0000_0055, 5'd3); wait_idle();
        cfg_err = 0;

        // Misaligned / unsupported: no bus request, immediate err
        exp_tx(32'd0, 5'd9, 1'b1, 0);
        send(7'b0000011, 3'b010, 32'h3000, 32'd1, 32'd0, 5'd9); wait_idle();
        exp_tx(32'd0, 5'd6, 1'b1, 0);
        send(7'b0000011, 3'b101, 32'h3001, 32'd0, 32'd0, 5'd6); wait_idle();
        exp_tx(32'd0, 5'd10, 1'b1, 0);
        send(7'b0000011, 3'b011, 32'h3000, 32'd0, 32'd0, 5'd10); wait_idle();
        exp_tx(32'd0, 5'd0, 1'b1, 0);
        send(7'b0100011, 3'b010, 32'h3002, 32'd0, 32'hFFFF_FFFF, 5'd2); wait_idle();

        // Non-memory opcode is swallowed
        send(7'b0110011, 3'b010, 32'h3000, 32'd0, 32'd0, 5'd1); wait_idle();

        // Request stall then timeout; late response must be ignored
        cfg_stall = 5; cfg_drop = 1; cfg_late = 20;
        exp_req(1'b0, 32'h4000, 4'b1111, 32'd0); exp_tx(32'd0, 5'd11, 1'b1, 15);
        send(7'b0000011, 3'b010, 32'h4000, 32'd0, 32'd0, 5'd11); wait_idle();
        repeat (12) @(posedge clk);
        #1 cfg_stall = 0; cfg_drop = 0; cfg_late = 0;

        // Recovery after all of the above
        cfg_rdata = 32'h7FFF_1234;
        exp_req(1'b0, 32'h5000, 4'b1100, 32'd0); exp_tx(32'h0000_7FFF, 5'd12, 1'b0, 1);
        send(7'b0000011, 3'b101, 32'h5000, 32'd2, 32'd0, 5'd12); wait_idle();

        repeat (3) @(posedge clk);
        done = 1;
    end

    // Monitor: compare everything the DUT presents against the queues
    initial begin
        int  cyc = 0, wait_cnt = 0;
        bit  prev_rstn = 0, drop_pend = 0;
        req_exp_t r;
        tx_exp_t  t;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                chk("rst_bus_out", {26'd0, req_valid, req_wen, req_addr, req_wstrb, req_wdata}, 96'd0);
                chk("rst_tx_out", {56'd0, tx_valid, tx_data, tx_rd, tx_err, busy}, 96'd0);
                prev_rstn = 0; drop_pend = 0; wait_cnt = 0;
                continue;
            end
            if (!prev_rstn) chk("rx_ready_after_rst", {95'd0, rx_ready}, 96'd1);
            prev_rstn = 1;
            if (drop_pend) begin
                chk("dropped_op_idle", {95'd0, busy}, 96'd0);
                drop_pend = 0;
            end
            if (rx_valid && rx_ready) begin
                wait_cnt = 0;
                if (rx_opcode != 7'b0000011 && rx_opcode != 7'b0100011) drop_pend = 1;
            end
            if (busy && !req_valid && !tx_valid) wait_cnt++;
            if (req_valid) begin
                if (req_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_req: addr %0h, want none", req_addr);
                end else begin
                    r = req_q[0];
                    chk("req_payload", {26'd0, req_wen, req_addr, req_wstrb, req_wdata},
                        {26'd0, r.wen, r.addr, r.wstrb, r.wdata});
                    if (req_ready) begin void'(req_q.pop_front()); wait_cnt = 0; end
                end
            end
            if (tx_valid) begin
                if (tx_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_tx: data %0h err %0b, want none", tx_data, tx_err);
                end else begin
                    t = tx_q[0];
                    chk("tx_result", {58'd0, tx_data, tx_rd, tx_err}, {58'd0, t.data, t.rd, t.err});
                    if (tx_ready) begin
                        void'(tx_q.pop_front());
                        chk("tx_wait_cycles", 96'(wait_cnt), 96'(t.wait_cyc));
                    end
                end
            end
        end
        chk("watchdog", 96'(cyc >= 20000), 96'd0);
        chk("stim_bounds", 96'(stim_to), 96'd0);
        chk("req_q_drained", 96'(req_q.size()), 96'd0);
        chk("tx_q_drained", 96'(tx_q.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/core_lsu_mc.md
# core_lsu_mc

Multi-cycle load/store unit for the RV32 core, sitting between IDU and WBU. It replaces the single-cycle LSU, which relied on a combinational memory read. Each instruction is turned into a valid/ready bus request with byte strobes, and the block waits for a response of variable latency. Load data is aligned and sign/zero-extended, and errors (misalignment, bus error, timeout) are reported to WBU.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported and must be checked at elaboration.
- `TIMEOUT_W`, 8: width of the response-wait counter; timeout fires after 2^TIMEOUT_W−1 cycles in WAIT.
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `lsu_rx_valid` / `lsu_rx_ready`  in/out  1  IDU handshake
- `lsu_rx_opcode`  in  7  load or store opcode; any other value is accepted and dropped with no effect
- `lsu_rx_func3`  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- `lsu_rx_rs1_data`, `lsu_rx_rs2_data`, `lsu_rx_imme`  in  XLEN  base, store data, offset
- `lsu_rx_rd_idx`  in  5  load destination
- `lsu_bus_req_valid` / `lsu_bus_req_ready`  out/in  1  bus request handshake
- `lsu_bus_req_wen`  out  1  1 = store
- `lsu_bus_req_addr`  out  XLEN  word-aligned address (addr[1:0] = 0)
- `lsu_bus_req_wstrb`  out  4  byte strobes
- `lsu_bus_req_wdata`  out  XLEN  store data, lane-shifted
- `lsu_bus_rsp_valid`  in  1  response strobe; always accepted in WAIT
- `lsu_bus_rsp_err`  in  1  bus error, qualified by rsp_valid
- `lsu_bus_rsp_rdata`  in  XLEN  raw read word
- `lsu_tx_valid` / `lsu_tx_ready`  out/in  1  WBU handshake
- `lsu_tx_data`  out  XLEN  extended load data; zero on error
- `lsu_tx_rd_idx`  out  5  destination; 0 for stores
- `lsu_tx_err`  out  1  access faulted
- `lsu_busy`  out  1  state ≠ IDLE

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **Request latch:** `lsu_rx_ready` = (state == IDLE). On rx handshake the block latches opcode, func3, rd_idx, ea = rs1 + imme (mod 2^32), and rs2.
- **Alignment:**
  - Misaligned = (h/hu and ea[0]) or (w and ea[1:0] ≠ 0).
  - Misaligned → RESP with err=1, no bus request.
  - Otherwise → REQ.
- **REQ:**
  - req_valid=1, holding addr = {ea[31:2], 2'b00}.
  - wstrb: b → 0001<<ea[1:0]; h → 0011<<ea[1:0]; w → 1111.
  - wdata = rs2 replicated per size, i.e. {4{rs2[7:0]}} for b and {2{rs2[15:0]}} for h.
  - Loads drive the same wstrb.
  - On req_ready → WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - On rsp_valid: if rsp_err or the access is a load → RESP; otherwise (store OK) → IDLE.
  - When the counter reaches all-ones without rsp_valid → RESP with err=1.
  - A late response after a timeout is ignored.
- **Load extension:** the byte/half is selected by ea[1:0] / ea[1]. b/h sign-extend; bu/hu zero-extend.
- **RESP:** tx_valid=1 with data, rd_idx, err stable until tx_ready, then → IDLE.
- **Unsupported func3** (011, 110, 111): treated as misaligned, giving err=1.

## Timing
- All outputs reset to 0; state resets to IDLE and the counter to 0.
- A reset mid-transaction abandons it. No request is re-issued.
- Minimum latency for a load, rx handshake to tx_valid: 3 cycles (REQ 1 cycle with req_ready=1, response 1 cycle later).
- Minimum latency for a store, rx handshake back to rx_ready: 3 cycles.
- Throughput is one access in flight. The next rx is accepted the cycle after the tx handshake, or after the store rsp.
- req_valid, once raised, must not drop, and its payload must not change until req_ready.
- rsp_valid in the same cycle the counter reaches its limit counts as a response, not a timeout.
- tx_ready held low stalls in RESP indefinitely and does not touch the counter.

## Configuration
- `LSU_DEBUG_DISPLAY_EN` defined: `$display` on each bus request (address, wstrb, wdata) and on each response (rdata, err) when rstn=1. Not synthesisable.
- Undefined: no display code is compiled; behaviour is otherwise identical.

## Structure
- Shared package `core_pkg`:
  - opcode constants LOAD=7'b0000011, STORE=7'b0100011;
  - func3 constants LSU_B/H/W/BU/HU;
  - LSU state enum.
- Sub-module `core_lsu_align`: purely combinational strobe/wdata generation and load extraction/extension. The FSM and counter stay in `core_lsu_mc`.

## Test plan
- **lw, word load:**
  - Stimulus: rs1=0x1000, imme=4; bus returns 0xDEADBEEF one cycle after req_ready.
  - Response: addr=0x1004, wstrb=1111, tx_data=0xDEADBEEF, rd_idx preserved, err=0.
- **lb / lbu, byte extension:**
  - Stimulus: ea=0x1003, rdata=0x80FF_0000.
  - Response: lb → 0xFFFFFF80, lbu → 0x00000080.
- **sh, half store:**
  - Stimulus: ea=0x2002, rs2=0x1234ABCD.
  - Response: wstrb=1100, wdata=0xABCDABCD, no tx after an OK rsp.
- **lw, misaligned:**
  - Stimulus: ea=0x3001.
  - Response: no req_valid, tx_valid with err=1, data=0.
- **Bus backpressure and timeout:**
  - Stimulus: req_ready low for 5 cycles (payload stable), then rsp never arrives with TIMEOUT_W=4.
  - Response: tx err=1 after 15 WAIT cycles; a late rsp_valid is ignored.
- **Async reset during WAIT:**
  - Stimulus: assert rstn=0 while in WAIT.
  - Response: all outputs 0, lsu_rx_ready=1 after release.
